// File: rtl/dvi_pixel_formatter_if.sv
// Pixel formatter port bundle: raster timing, RGB pixels, source select in; formatted DVI halves out.
// Pure signal container, no latency of its own.
// No backpressure: one pixel per clock, the raster source never stalls.
interface dvi_pixel_formatter_if #(
  parameter int COLOR_W = 8,
  parameter int DATA_W  = 12
);
  logic               hsync_in;
  logic               vsync_in;
  logic               de_in;
  logic [COLOR_W-1:0] red_in;
  logic [COLOR_W-1:0] green_in;
  logic [COLOR_W-1:0] blue_in;
  logic [1:0]         mode_in;
  logic [23:0]        solid_rgb;

  logic               HSYNC;
  logic               VSYNC;
  logic               DE;
  logic [DATA_W-1:0]  DVI_D0;
  logic [DATA_W-1:0]  DVI_D1;
  logic [1:0]         mode_active;
  logic [15:0]        frame_cnt;

  // Raster/pixel source side
  modport master (
    output hsync_in, vsync_in, de_in, red_in, green_in, blue_in, mode_in, solid_rgb,
    input  HSYNC, VSYNC, DE, DVI_D0, DVI_D1, mode_active, frame_cnt
  );

  // Formatter side
  modport slave (
    input  hsync_in, vsync_in, de_in, red_in, green_in, blue_in, mode_in, solid_rgb,
    output HSYNC, VSYNC, DE, DVI_D0, DVI_D1, mode_active, frame_cnt
  );
endinterface

// File: rtl/dvi_pixel_formatter.sv
// Expands RGB to 8 bpc, optionally substitutes a test source, formats data halves for the DVI DDR outputs.
// Latency: exactly PIPE cycles from all inputs to HSYNC/VSYNC/DE/DVI_D0/DVI_D1, all mutually aligned.
// No backpressure: streaming pixel path, one pixel accepted and produced every clock.
module dvi_pixel_formatter #(
  parameter int COLOR_W = 8,
  parameter int DATA_W  = 12,
  parameter int PIPE    = 2,
  parameter int BAR_W   = 80,
  parameter int HS_INV  = 0,
  parameter int VS_INV  = 0
) (
  input logic              clk,
  input logic              rst,
  dvi_pixel_formatter_if.slave bus
);

  // Stage 1 plus the pure delay stages; the output stage is separate
  localparam int DLY = PIPE - 1;
  localparam int CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic HS_POL = (HS_INV != 0);
  localparam logic VS_POL = (VS_INV != 0);

  // MSB replication: output bit k repeats the input MSB-first, cycling through the channel
  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
    logic [7:0] res;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      res[7-k] = c[COLOR_W-1-(k % COLOR_W)];
    end
    return res;
  endfunction

  logic [1:0]  mode_q;
  logic [15:0] frame_q;
  logic        vs_q;
  logic        vs_rise;

  assign vs_rise = bus.vsync_in & ~vs_q;

  // Mode and frame counter only change on a vsync rising edge, so sources switch between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q    <= 1'b1;
      mode_q  <= 2'b00;
      frame_q <= 16'h0000;
    end else begin
      vs_q <= bus.vsync_in;
      if (vs_rise) begin
        mode_q  <= bus.mode_in;
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;

  // Bar position within the line; any blank cycle restarts the line at bar 0
  always_ff @(posedge clk) begin
    if (rst || !bus.de_in) begin
      bar_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt <= '0;
      if (bar_idx != 3'd7) begin
        bar_idx <= bar_idx + 3'd1;
      end
    end else begin
      bar_cnt <= bar_cnt + CNT_ONE;
    end
  end

  logic [23:0] bar_rgb;
  logic [23:0] pix_sel;

  // Test-source colour and source selection for the pixel sampled this cycle
  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    pix_sel = 24'h000000;
    case (mode_q)
      2'b00:   pix_sel = {expand(bus.red_in), expand(bus.green_in), expand(bus.blue_in)};
      2'b01:   pix_sel = bar_rgb;
      2'b10:   pix_sel = bus.solid_rgb;
      default: pix_sel = 24'h000000;
    endcase
  end

  logic        hs_d  [DLY];
  logic        vs_d  [DLY];
  logic        de_d  [DLY];
  logic [23:0] pix_d [DLY];

  // Stage 1 captures sync and the selected pixel; later entries are plain delay
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) begin
        hs_d[i]  <= 1'b1;
        vs_d[i]  <= 1'b1;
        de_d[i]  <= 1'b0;
        pix_d[i] <= 24'h000000;
      end
    end else begin
      hs_d[0]  <= bus.hsync_in;
      vs_d[0]  <= bus.vsync_in;
      de_d[0]  <= bus.de_in;
      pix_d[0] <= pix_sel;
      for (int i = 1; i < DLY; i++) begin
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
        de_d[i]  <= de_d[i-1];
        pix_d[i] <= pix_d[i-1];
      end
    end
  end

  logic [DATA_W-1:0] fmt_d0;
  logic [DATA_W-1:0] fmt_d1;

  if (DATA_W == 12) begin : g_mux12
    // Rising half carries R and upper G, falling half carries lower G and B
    assign fmt_d0 = pix_d[DLY-1][23:12];
    assign fmt_d1 = pix_d[DLY-1][11:0];
  end else begin : g_full24
    assign fmt_d0 = pix_d[DLY-1];
    assign fmt_d1 = pix_d[DLY-1];
  end

  logic              hs_o;
  logic              vs_o;
  logic              de_o;
  logic [DATA_W-1:0] d0_o;
  logic [DATA_W-1:0] d1_o;

  // Output stage: apply sync polarity, format and blank data outside active video
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_o <= 1'b1 ^ HS_POL;
      vs_o <= 1'b1 ^ VS_POL;
      de_o <= 1'b0;
      d0_o <= '0;
      d1_o <= '0;
    end else begin
      hs_o <= hs_d[DLY-1] ^ HS_POL;
      vs_o <= vs_d[DLY-1] ^ VS_POL;
      de_o <= de_d[DLY-1];
      d0_o <= de_d[DLY-1] ? fmt_d0 : '0;
      d1_o <= de_d[DLY-1] ? fmt_d1 : '0;
    end
  end

  assign bus.HSYNC       = hs_o;
  assign bus.VSYNC       = vs_o;
  assign bus.DE          = de_o;
  assign bus.DVI_D0      = d0_o;
  assign bus.DVI_D1      = d1_o;
  assign bus.mode_active = mode_q;
  assign bus.frame_cnt   = frame_q;

endmodule
